// File: rtl/pc_cmd_pkg.sv
// pc_cmd_pkg: shared byte codes and parser state encoding for the PC command link
package pc_cmd_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam logic [7:0] OP_START = 8'hAB;
  localparam logic [7:0] OP_STOP = 8'hCD;
  localparam logic [7:0] OP_SET_PERIOD = 8'h51;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;
  typedef enum logic [2:0] {S_IDLE, S_OP, S_LEN, S_PAYLOAD, S_CSUM, S_EXEC} state_t;
endpackage

// File: rtl/pc_cmd_parser_if.sv
// pc_cmd_parser_if: byte stream from uart_rx and response handshake to uart_tx
interface pc_cmd_parser_if;
  logic rx_ready;
  logic [7:0] rx_data;
  logic tx_start;
  logic [7:0] tx_data;
  logic tx_busy;
  modport master(output rx_ready, rx_data, tx_busy, input tx_start, tx_data);
  modport slave(input rx_ready, rx_data, tx_busy, output tx_start, tx_data);
endinterface

// File: rtl/resp_tx_ctrl.sv
// resp_tx_ctrl: one-entry response register with uart_tx start/busy handshake
module resp_tx_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] req_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       resp_drop
);
  logic sent;
  // The entry stays occupied from queueing until uart_tx has taken the byte and gone idle again
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start <= 1'b0;
      tx_data <= '0;
      sent <= 1'b0;
      resp_drop <= 1'b0;
    end else begin
      resp_drop <= req && (tx_start || sent);
      if (tx_start && tx_busy) begin
        tx_start <= 1'b0;
        sent <= 1'b1;
      end else if (sent && !tx_busy) begin
        sent <= 1'b0;
      end
      if (req && !tx_start && !sent) begin
        tx_start <= 1'b1;
        tx_data <= req_data;
      end
    end
  end
endmodule

// File: rtl/pc_cmd_parser.sv
// pc_cmd_parser: framed PC command decoder driving vector enable, dump period and ACK/NAK replies
module pc_cmd_parser
  import pc_cmd_pkg::*;
#(
  parameter int          MAX_LEN = 4,
  parameter int          TIMEOUT = 153600,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd16
) (
  input  logic              clk,
  input  logic              rst,
  pc_cmd_parser_if.slave    bus,
  output logic              vector_en,
  output logic [15:0]       dump_period,
  output logic              cmd_valid,
  output logic [7:0]        cmd_op,
  output logic              err_csum,
  output logic              err_len,
  output logic              err_timeout,
  output logic              resp_drop
);
  localparam logic [17:0] TMO_LAST = 18'(TIMEOUT - 1);
  localparam logic [7:0] MAX_L = 8'(MAX_LEN);
  state_t state;
  logic [7:0] d, op, len, csum;
  logic [15:0] pay;
  logic [2:0] cnt;
  logic [17:0] tmo;
  logic len_bad, csum_bad, exec_ok, req;
  logic [7:0] req_data;
  assign d = bus.rx_data;
  // Error responses are queued in the cycle of the offending byte so the NAK starts one cycle later
  always_comb begin
    len_bad = state == S_LEN && bus.rx_ready && d > MAX_L;
    csum_bad = state == S_CSUM && bus.rx_ready && d != csum;
    exec_ok = (op == OP_START || op == OP_STOP) ? len == 8'd0 :
              (op == OP_SET_PERIOD) ? len == 8'd2 && pay != 16'd0 : 1'b0;
    req = state == S_EXEC || len_bad || csum_bad;
    req_data = (state == S_EXEC && exec_ok) ? RESP_ACK : RESP_NAK;
  end
  // Frame state machine, checksum accumulation, timeout and command execution
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      op <= '0;
      len <= '0;
      csum <= '0;
      pay <= '0;
      cnt <= '0;
      tmo <= '0;
      vector_en <= 1'b0;
      dump_period <= DEFAULT_PERIOD;
      cmd_valid <= 1'b0;
      cmd_op <= '0;
      err_csum <= 1'b0;
      err_len <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      cmd_valid <= state == S_EXEC;
      err_csum <= csum_bad;
      err_len <= len_bad;
      err_timeout <= 1'b0;
      tmo <= (state == S_IDLE || bus.rx_ready) ? '0 : tmo + 18'd1;
      if (state == S_EXEC) begin
        cmd_op <= op;
        if (exec_ok && op == OP_START) vector_en <= 1'b1;
        if (exec_ok && op == OP_STOP) vector_en <= 1'b0;
        if (exec_ok && op == OP_SET_PERIOD) dump_period <= pay;
      end
      if (bus.rx_ready) begin
        case (state)
          S_IDLE, S_EXEC: state <= d == SYNC_BYTE ? S_OP : S_IDLE;
          S_OP: begin
            op <= d;
            csum <= d;
            state <= S_LEN;
          end
          S_LEN: begin
            len <= d;
            csum <= csum ^ d;
            cnt <= '0;
            state <= d == 8'd0 ? S_CSUM : len_bad ? S_IDLE : S_PAYLOAD;
          end
          S_PAYLOAD: begin
            pay <= {pay[7:0], d};
            csum <= csum ^ d;
            cnt <= cnt + 3'd1;
            if (cnt + 3'd1 == len[2:0]) state <= S_CSUM;
          end
          S_CSUM: state <= csum_bad ? S_IDLE : S_EXEC;
          default: state <= S_IDLE;
        endcase
      end else if (state == S_EXEC) begin
        state <= S_IDLE;
      end else if (state != S_IDLE && tmo == TMO_LAST) begin
        state <= S_IDLE;
        err_timeout <= 1'b1;
      end
    end
  end
  resp_tx_ctrl u_resp (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .tx_busy(bus.tx_busy),
    .tx_start(bus.tx_start),
    .tx_data(bus.tx_data),
    .resp_drop(resp_drop)
  );
endmodule
